axis_frame_sink: RTL and testbench
==================================

AXIS_FRAME_SINK -- requirements
Module: axis_frame_sink

Interface
REQ-001 Parameter DATA_W, 8, stream data width in bits.
REQ-002 Parameter DEPTH, 1024, capture buffer entries; SHALL be a power of two.
REQ-003 Parameter ADDR_W, $clog2(DEPTH), buffer address width.
REQ-004 clk_i  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 resetn_i  in  1  reset; asynchronous, active-low.
REQ-006 s_axis_tdata  in  DATA_W  stream beat data.
REQ-007 s_axis_tvalid  in  1  upstream beat valid.
REQ-008 s_axis_tready  out  1  sink ready; SHALL be driven from registered state only, with no combinational path from any input.
REQ-009 s_axis_tlast  in  1  last beat of frame.
REQ-010 frame_len_i  in  ADDR_W+1  expected beats per frame; sampled only on an accepted arm_i.
REQ-011 arm_i  in  1  one-cycle start-capture request.
REQ-012 rd_addr_i  in  ADDR_W  readback address.
REQ-013 rd_data_o  out  DATA_W  readback data.
REQ-014 busy_o  out  1  high in CAPTURE or DRAIN.
REQ-015 done_o  out  1  high in DONE.
REQ-016 err_early_o  out  1  tlast seen before frame_len beats.
REQ-017 err_late_o  out  1  frame_len beats reached without tlast.
REQ-018 beat_cnt_o  out  ADDR_W+1  number of beats written for the current or last frame.

Function
REQ-019 State machine SHALL have exactly four states: IDLE, CAPTURE, DRAIN, DONE.
REQ-020 Handshake: a beat SHALL transfer on a rising edge where tvalid and tready are both 1.
REQ-021 tready SHALL be 1 in CAPTURE and DRAIN, and 0 in IDLE and DONE.
REQ-022 Arm acceptance, IDLE or DONE, with 1 <= frame_len_i <= DEPTH:
- latch length L;
- clear beat_cnt, err_early and err_late;
- go to CAPTURE next cycle.
REQ-023 arm_i SHALL be ignored when frame_len_i is 0 or greater than DEPTH, and in CAPTURE or DRAIN; state and flags SHALL be unchanged.
REQ-024 CAPTURE transfer: write tdata to mem[beat_cnt], then increment beat_cnt; next state depends on n = beat_cnt+1:
- tlast=1, n==L: go to DONE;
- tlast=1, n<L: set err_early, go to DONE;
- tlast=0, n==L: set err_late, go to DRAIN;
- otherwise: stay in CAPTURE.
REQ-025 DRAIN: accept and discard beats (no write, beat_cnt frozen); a transfer with tlast=1 SHALL go to DONE.
REQ-026 Throughput SHALL be one beat per cycle with tvalid held high; tvalid gaps SHALL only stall, with no data loss or duplication.
REQ-027 tready SHALL fall in the cycle immediately after the transfer that enters DONE.
REQ-028 Readback: rd_data_o = mem[rd_addr_i] with 1-cycle registered latency, available in every state.
REQ-029 Simultaneous write and read of the same address SHALL return the old contents (read-first).
REQ-030 beat_cnt SHALL never exceed L; no buffer address wrap-around SHALL be possible.

Reset
REQ-031 resetn_i low SHALL immediately force:
- state to IDLE;
- s_axis_tready, busy_o, done_o, err_early_o, err_late_o to 0;
- beat_cnt_o to 0;
- rd_data_o to 0.
REQ-032 Buffer contents SHALL NOT be reset.
REQ-033 Reset mid-frame SHALL abandon the frame; a fresh arm_i is required to capture again.

Verification
REQ-034 Nominal frame: L=4, arm, send 10,20,30,40 back-to-back with tlast on 40 -> done_o=1 the cycle after the 4th transfer, beat_cnt_o=4, no errors, readback 0..3 = 10,20,30,40.
REQ-035 Stalls: repeat REQ-034 with tvalid low on alternate cycles -> identical buffer contents, beat_cnt_o=4, no errors.
REQ-036 Early tlast: L=4, send 7,8 with tlast on 8 -> err_early_o=1, beat_cnt_o=2, done_o=1, tready=0 next cycle.
REQ-037 Late tlast: L=3, send 1..5 with tlast on 5:
- err_late_o=1, beat_cnt_o=3;
- mem[0..2] = 1,2,3, mem[3] unchanged;
- DRAIN for beats 4-5, done_o=1 after beat 5.
REQ-038 Illegal arm: arm with frame_len_i=0 or DEPTH+1 -> remains IDLE, tready=0; arm during CAPTURE -> L and beat_cnt unchanged.
REQ-039 Reset mid-frame: after 2 of 4 beats pull resetn_i low -> tready, busy_o, beat_cnt_o = 0 without a clock edge; re-arm with L=2, send 5,6 -> done_o=1, mem[0..1] = 5,6.

Source files
------------

// File: rtl/axis_frame_sink.sv
// AXI-Stream frame capture sink: arms for an expected frame length, stores beats into an
// internal buffer, flags early/late tlast and offers registered random-access readback.
module axis_frame_sink #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic [ADDR_W:0]   frame_len_i,
  input  logic              arm_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_early_o,
  output logic              err_late_o,
  output logic [ADDR_W:0]   beat_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_beat_cnt;
  logic              r_tready;
  logic              r_busy;
  logic              r_done;
  logic              r_err_early;
  logic              r_err_late;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_xfer;
  logic              w_arm_ok;
  logic              w_wr_en;
  logic [ADDR_W:0]   w_cnt_inc;

  assign w_xfer    = s_axis_tvalid & r_tready;
  assign w_arm_ok  = arm_i && (frame_len_i != '0) && (frame_len_i <= LEN_MAX) &&
                     ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_wr_en   = w_xfer && (r_state == S_CAPTURE);
  assign w_cnt_inc = r_beat_cnt + 1'b1;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_beat_cnt  <= '0;
      r_tready    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err_early <= 1'b0;
      r_err_late  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm_ok) begin
            r_state     <= S_CAPTURE;
            r_len       <= frame_len_i;
            r_beat_cnt  <= '0;
            r_err_early <= 1'b0;
            r_err_late  <= 1'b0;
            r_tready    <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        S_CAPTURE: begin
          if (w_xfer) begin
            r_beat_cnt <= w_cnt_inc;
            if (s_axis_tlast) begin
              r_state     <= S_DONE;
              r_tready    <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_err_early <= (w_cnt_inc != r_len);
            end else if (w_cnt_inc == r_len) begin
              // Length reached without tlast: swallow the rest of the frame.
              r_state    <= S_DRAIN;
              r_err_late <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_xfer && s_axis_tlast) begin
            r_state  <= S_DONE;
            r_tready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tready <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  // Buffer has no reset so it maps onto block RAM; beat_cnt < L <= DEPTH while capturing.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_beat_cnt[ADDR_W-1:0]] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign s_axis_tready = r_tready;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_early_o   = r_err_early;
  assign err_late_o    = r_err_late;
  assign beat_cnt_o    = r_beat_cnt;
  assign rd_data_o     = r_rd_data;

endmodule

// File: tb/tb_axis_frame_sink.sv
// Bench for axis_frame_sink: directed frames with literal expectations, then random
// traffic checked every cycle against a frame-level behavioural model.
module tb_axis_frame_sink;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk_i = 1'b0;
  logic              resetn_i;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic [ADDR_W:0]   frame_len_i;
  logic              arm_i;
  logic [ADDR_W-1:0] rd_addr_i;
  logic [DATA_W-1:0] rd_data_o;
  logic              busy_o;
  logic              done_o;
  logic              err_early_o;
  logic              err_late_o;
  logic [ADDR_W:0]   beat_cnt_o;

  axis_frame_sink #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk_i), .resetn_i(resetn_i),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .frame_len_i(frame_len_i), .arm_i(arm_i),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o),
    .busy_o(busy_o), .done_o(done_o),
    .err_early_o(err_early_o), .err_late_o(err_late_o),
    .beat_cnt_o(beat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is "open" from accepted arm until tlast; beats are stored
  // while fewer than L have been kept, afterwards they are dropped.
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_known [DEPTH];
  bit                m_open, m_done, m_ee, m_el;
  int                m_len, m_cnt;
  logic [DATA_W-1:0] m_rd;
  bit                m_rd_known;

  initial for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

  always @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      m_open = 0; m_done = 0; m_ee = 0; m_el = 0; m_cnt = 0;
      m_rd = '0; m_rd_known = 1;
    end else begin
      m_rd       = m_mem[rd_addr_i];
      m_rd_known = m_known[rd_addr_i];
      if (!m_open) begin
        if (arm_i && frame_len_i >= 1 && frame_len_i <= DEPTH) begin
          m_len = int'(frame_len_i);
          m_cnt = 0; m_ee = 0; m_el = 0; m_open = 1; m_done = 0;
        end
      end else if (s_axis_tvalid) begin
        if (m_cnt < m_len && !m_el) begin
          m_mem[m_cnt]   = s_axis_tdata;
          m_known[m_cnt] = 1;
          m_cnt++;
          if (!s_axis_tlast && m_cnt == m_len) m_el = 1;
          if (s_axis_tlast && m_cnt < m_len) m_ee = 1;
        end
        if (s_axis_tlast) begin
          m_open = 0;
          m_done = 1;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("tready", s_axis_tready, m_open);
      check("busy", busy_o, m_open);
      check("done", done_o, m_done);
      check("err_early", err_early_o, m_ee);
      check("err_late", err_late_o, m_el);
      check("beat_cnt", beat_cnt_o, m_cnt);
      if (m_rd_known) check("rd_data", rd_data_o, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic arm(input int len);
    arm_i = 1'b1;
    frame_len_i = (ADDR_W+1)'(len);
    tick();
    arm_i = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input bit last);
    bit sent = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    for (int n = 0; n < 20 && !sent; n++) begin
      if (s_axis_tready) sent = 1;
      tick();
    end
    if (!sent) check("beat_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic readback(input int addr, input logic [7:0] exp);
    rd_addr_i = ADDR_W'(addr);
    tick();
    check("readback", rd_data_o, exp);
  endtask

  task automatic do_reset();
    resetn_i = 1'b0;
    tick();
    resetn_i = 1'b1;
  endtask

  initial begin
    resetn_i = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
    frame_len_i = '0; arm_i = 0; rd_addr_i = '0;
    #2;
    check("rst_tready", s_axis_tready, 0);
    check("rst_rd_data", rd_data_o, 0);
    check("rst_cnt", beat_cnt_o, 0);
    chk_en = 1'b1;
    tick(); tick();
    resetn_i = 1'b1;

    // Nominal frame
    arm(4);
    beat(8'd10, 0); beat(8'd20, 0); beat(8'd30, 0); beat(8'd40, 1);
    check("nom_done", done_o, 1);
    check("nom_cnt", beat_cnt_o, 4);
    check("nom_err", {err_early_o, err_late_o}, 0);
    check("nom_tready", s_axis_tready, 0);
    readback(0, 8'd10); readback(1, 8'd20); readback(2, 8'd30); readback(3, 8'd40);

    // Stalled frame writes identical content
    arm(4);
    beat(8'd10, 0); tick(); beat(8'd20, 0); tick(); beat(8'd30, 0); tick(); beat(8'd40, 1);
    check("stall_cnt", beat_cnt_o, 4);
    check("stall_err", {err_early_o, err_late_o}, 0);
    readback(0, 8'd10); readback(3, 8'd40);

    // Early tlast
    arm(4);
    beat(8'd7, 0); beat(8'd8, 1);
    check("early_err", err_early_o, 1);
    check("early_cnt", beat_cnt_o, 2);
    check("early_done", done_o, 1);
    check("early_tready", s_axis_tready, 0);

    // Late tlast
    arm(3);
    beat(8'd1, 0); beat(8'd2, 0); beat(8'd3, 0);
    check("late_err", err_late_o, 1);
    check("late_cnt", beat_cnt_o, 3);
    beat(8'd4, 0);
    check("late_drain_busy", busy_o, 1);
    beat(8'd5, 1);
    check("late_done", done_o, 1);
    check("late_cnt_final", beat_cnt_o, 3);
    readback(0, 8'd1); readback(1, 8'd2); readback(2, 8'd3); readback(3, 8'd40);

    // Illegal arms
    do_reset();
    arm(0);
    check("ill0_tready", s_axis_tready, 0);
    arm(DEPTH + 1);
    check("ill17_tready", s_axis_tready, 0);
    check("ill17_busy", busy_o, 0);
    arm(4);
    beat(8'd11, 0);
    arm(2);
    beat(8'd12, 0); beat(8'd13, 0); beat(8'd14, 1);
    check("armcap_err", {err_early_o, err_late_o}, 0);
    check("armcap_cnt", beat_cnt_o, 4);

    // Reset mid-frame
    arm(4);
    beat(8'd1, 0); beat(8'd2, 0);
    resetn_i = 1'b0;
    #2;
    check("midrst_tready", s_axis_tready, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_cnt", beat_cnt_o, 0);
    tick();
    resetn_i = 1'b1;
    arm(2);
    beat(8'd5, 0); beat(8'd6, 1);
    check("rearm_done", done_o, 1);
    readback(0, 8'd5); readback(1, 8'd6);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      arm_i = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 7))
        0: frame_len_i = '0;
        1: frame_len_i = (ADDR_W+1)'(DEPTH + 1);
        default: frame_len_i = (ADDR_W+1)'($urandom_range(1, DEPTH));
      endcase
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tlast  = ($urandom_range(0, 5) == 0);
      s_axis_tdata  = DATA_W'($urandom);
      rd_addr_i     = ADDR_W'($urandom);
      resetn_i      = ($urandom_range(0, 399) != 0);
      tick();
    end
    resetn_i = 1'b1;
    arm_i = 0; s_axis_tvalid = 0;
    tick(); tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
